// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_ctrl
// Purpose  : Pipeline sequencing for the PPU: load-use bubbles, branch flush
//            and memory-busy freeze. Optional perf counters: HAZARD_PERF_CNT_EN
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int CNT_W             = 32
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic [4:0]       ID_rs1,
    input  logic [4:0]       ID_rs2,
    input  logic             ID_rs1_use,
    input  logic             ID_rs2_use,
    input  logic [4:0]       EX_rd,
    input  logic             EX_Load_Instr,
    input  logic             EX_RF_Enable,
    input  logic             EX_Branch_Taken,
    input  logic             Mem_Busy,
    output logic             PC_LE,
    output logic             IF_ID_LE,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Bubble,
    output logic             Pipe_Hold,
    output logic [1:0]       Ctrl_State
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] Stall_Count,
    output logic [CNT_W-1:0] Flush_Count
`endif
);

    localparam logic [1:0] c_ST_RUN        = 2'b00;
    localparam logic [1:0] c_ST_LOAD_STALL = 2'b01;
    localparam logic [3:0] c_STALL_RELOAD  = 4'(LOAD_STALL_CYCLES - 1);

    if (LOAD_STALL_CYCLES < 1 || LOAD_STALL_CYCLES > 15 || CNT_W < 1) begin : g_param_err
        $error("pipeline_hazard_ctrl: LOAD_STALL_CYCLES must be 1..15 and CNT_W >= 1");
    end

    logic [1:0] r_state;
    logic [3:0] r_cnt;
    logic [1:0] w_state_nxt;
    logic [3:0] w_cnt_nxt;
    logic       w_load_use;

    assign w_load_use = EX_Load_Instr & EX_RF_Enable & (EX_rd != 5'd0)
                      & ((ID_rs1_use & (ID_rs1 == EX_rd)) | (ID_rs2_use & (ID_rs2 == EX_rd)));

    assign Ctrl_State = r_state;

    always_comb begin
        PC_LE        = 1'b1;
        IF_ID_LE     = 1'b1;
        IF_ID_Flush  = 1'b0;
        ID_EX_Bubble = 1'b0;
        Pipe_Hold    = 1'b0;
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;

        if (Reset) begin
            PC_LE        = 1'b0;
            IF_ID_LE     = 1'b0;
            IF_ID_Flush  = 1'b1;
            ID_EX_Bubble = 1'b1;
            w_state_nxt  = c_ST_RUN;
            w_cnt_nxt    = 4'd0;
        end else if (Mem_Busy) begin
            // Freeze everything, including the stall countdown.
            PC_LE     = 1'b0;
            IF_ID_LE  = 1'b0;
            Pipe_Hold = 1'b1;
        end else if (EX_Branch_Taken) begin
            IF_ID_LE     = 1'b0;
            IF_ID_Flush  = 1'b1;
            ID_EX_Bubble = 1'b1;
            w_state_nxt  = c_ST_RUN;
            w_cnt_nxt    = 4'd0;
        end else begin
            case (r_state)
                c_ST_RUN: begin
                    if (w_load_use) begin
                        PC_LE        = 1'b0;
                        IF_ID_LE     = 1'b0;
                        ID_EX_Bubble = 1'b1;
                        if (LOAD_STALL_CYCLES > 1) begin
                            w_state_nxt = c_ST_LOAD_STALL;
                            w_cnt_nxt   = c_STALL_RELOAD;
                        end
                    end
                end
                c_ST_LOAD_STALL: begin
                    PC_LE        = 1'b0;
                    IF_ID_LE     = 1'b0;
                    ID_EX_Bubble = 1'b1;
                    if (r_cnt <= 4'd1) begin
                        w_state_nxt = c_ST_RUN;
                        w_cnt_nxt   = 4'd0;
                    end else begin
                        w_cnt_nxt = r_cnt - 4'd1;
                    end
                end
                default: begin
                    w_state_nxt = c_ST_RUN;
                    w_cnt_nxt   = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    // Both counters saturate rather than wrap.
    always_ff @(posedge clk) begin
        if (Reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!PC_LE && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (IF_ID_Flush && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

    assign Stall_Count = r_stall_cnt;
    assign Flush_Count = r_flush_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_hazard_ctrl
// Purpose  : Directed bench, two instances (1 and 3 bubbles per load-use).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       Reset, Mem_Busy, EX_Branch_Taken, EX_Load_Instr, EX_RF_Enable;
    logic [4:0] ID_rs1, ID_rs2, EX_rd;
    logic       ID_rs1_use, ID_rs2_use;

    logic       pc1, le1, fl1, bb1, hd1;
    logic       pc3, le3, fl3, bb3, hd3;
    logic [1:0] st1, st3;
    logic [4:0] w_o1, w_o3;

    int chk_cnt = 0;
    int err_cnt = 0;

    // Output vector order: {PC_LE, IF_ID_LE, IF_ID_Flush, ID_EX_Bubble, Pipe_Hold}
    localparam logic [4:0] c_N = 5'b11000;
    localparam logic [4:0] c_R = 5'b00110;
    localparam logic [4:0] c_S = 5'b00010;
    localparam logic [4:0] c_F = 5'b10110;
    localparam logic [4:0] c_H = 5'b00001;

    always #5 clk = ~clk;

    assign w_o1 = {pc1, le1, fl1, bb1, hd1};
    assign w_o3 = {pc3, le3, fl3, bb3, hd3};

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] sc1, fc1, sc3, fc3;
`endif

    pipeline_hazard_ctrl #(.LOAD_STALL_CYCLES(1), .CNT_W(32)) u_dut1 (
        .clk(clk), .Reset(Reset),
        .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_rs1_use(ID_rs1_use), .ID_rs2_use(ID_rs2_use),
        .EX_rd(EX_rd), .EX_Load_Instr(EX_Load_Instr), .EX_RF_Enable(EX_RF_Enable),
        .EX_Branch_Taken(EX_Branch_Taken), .Mem_Busy(Mem_Busy),
        .PC_LE(pc1), .IF_ID_LE(le1), .IF_ID_Flush(fl1), .ID_EX_Bubble(bb1),
        .Pipe_Hold(hd1), .Ctrl_State(st1)
`ifdef HAZARD_PERF_CNT_EN
        , .Stall_Count(sc1), .Flush_Count(fc1)
`endif
    );

    pipeline_hazard_ctrl #(.LOAD_STALL_CYCLES(3), .CNT_W(32)) u_dut3 (
        .clk(clk), .Reset(Reset),
        .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_rs1_use(ID_rs1_use), .ID_rs2_use(ID_rs2_use),
        .EX_rd(EX_rd), .EX_Load_Instr(EX_Load_Instr), .EX_RF_Enable(EX_RF_Enable),
        .EX_Branch_Taken(EX_Branch_Taken), .Mem_Busy(Mem_Busy),
        .PC_LE(pc3), .IF_ID_LE(le3), .IF_ID_Flush(fl3), .ID_EX_Bubble(bb3),
        .Pipe_Hold(hd3), .Ctrl_State(st3)
`ifdef HAZARD_PERF_CNT_EN
        , .Stall_Count(sc3), .Flush_Count(fc3)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs mid-cycle, check Mealy outputs, advance.
    task automatic cyc(input string tag,
                       input logic rst, input logic busy, input logic br,
                       input logic ld, input logic rf, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2,
                       input logic [4:0] e1, input logic [1:0] s1,
                       input logic [4:0] e3, input logic [1:0] s3);
        Reset = rst; Mem_Busy = busy; EX_Branch_Taken = br;
        EX_Load_Instr = ld; EX_RF_Enable = rf; EX_rd = rd;
        ID_rs1 = rs1; ID_rs1_use = u1; ID_rs2 = rs2; ID_rs2_use = u2;
        #1;
        check({tag, "/out1"},   32'(w_o1), 32'(e1));
        check({tag, "/state1"}, 32'(st1),  32'(s1));
        check({tag, "/out3"},   32'(w_o3), 32'(e3));
        check({tag, "/state3"}, 32'(st3),  32'(s3));
        @(negedge clk);
    endtask

    task automatic idle(input string tag, input logic [4:0] e1, input logic [1:0] s1,
                        input logic [4:0] e3, input logic [1:0] s3);
        cyc(tag, 0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, e1, s1, e3, s3);
    endtask

    initial begin
        Reset = 1'b1; Mem_Busy = 1'b0; EX_Branch_Taken = 1'b0;
        EX_Load_Instr = 1'b0; EX_RF_Enable = 1'b0; EX_rd = 5'd0;
        ID_rs1 = 5'd0; ID_rs2 = 5'd0; ID_rs1_use = 1'b0; ID_rs2_use = 1'b0;
        @(negedge clk);

        cyc("rst_a", 1, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, c_R, 2'b00, c_R, 2'b00);
        cyc("rst_b", 1, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, c_R, 2'b00, c_R, 2'b00);
        idle("run0", c_N, 2'b00, c_N, 2'b00);

        // Load to x5, ID reads x5 via rs1
        cyc("lu_x5", 0, 0, 0, 1, 1, 5'd5, 5'd5, 1, 5'd0, 0, c_S, 2'b00, c_S, 2'b00);
        idle("lu_x5_p1", c_N, 2'b00, c_S, 2'b01);
        idle("lu_x5_p2", c_N, 2'b00, c_S, 2'b01);
        idle("lu_x5_p3", c_N, 2'b00, c_N, 2'b00);

        // Near-miss patterns that must not stall
        cyc("rd_x0",   0, 0, 0, 1, 1, 5'd0, 5'd0, 1, 5'd0, 1, c_N, 2'b00, c_N, 2'b00);
        cyc("no_rfen", 0, 0, 0, 1, 0, 5'd5, 5'd5, 1, 5'd5, 1, c_N, 2'b00, c_N, 2'b00);
        cyc("no_use",  0, 0, 0, 1, 1, 5'd5, 5'd5, 0, 5'd3, 1, c_N, 2'b00, c_N, 2'b00);
        cyc("not_ld",  0, 0, 0, 0, 1, 5'd5, 5'd5, 1, 5'd5, 1, c_N, 2'b00, c_N, 2'b00);

        // Load to x7 used via rs2
        cyc("lu_x7", 0, 0, 0, 1, 1, 5'd7, 5'd7, 0, 5'd7, 1, c_S, 2'b00, c_S, 2'b00);
        idle("lu_x7_p1", c_N, 2'b00, c_S, 2'b01);
        idle("lu_x7_p2", c_N, 2'b00, c_S, 2'b01);
        idle("lu_x7_p3", c_N, 2'b00, c_N, 2'b00);

        // Branch together with load-use: flush wins
        cyc("br_lu", 0, 0, 1, 1, 1, 5'd7, 5'd0, 0, 5'd7, 1, c_F, 2'b00, c_F, 2'b00);
        // Branch aborts a stall in progress
        cyc("lu_b4br", 0, 0, 0, 1, 1, 5'd9, 5'd9, 1, 5'd0, 0, c_S, 2'b00, c_S, 2'b00);
        cyc("br_in_ls", 0, 0, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, c_F, 2'b00, c_F, 2'b01);
        idle("after_br", c_N, 2'b00, c_N, 2'b00);
`ifdef HAZARD_PERF_CNT_EN
        check("stall_cnt1_a", sc1, 32'd3);
        check("flush_cnt1_a", fc1, 32'd2);
        check("stall_cnt3_a", sc3, 32'd7);
        check("flush_cnt3_a", fc3, 32'd2);
`endif

        // Mem_Busy for 4 cycles while dut3 sits in LOAD_STALL with counter 2
        cyc("lu_b4busy", 0, 0, 0, 1, 1, 5'd4, 5'd4, 1, 5'd0, 0, c_S, 2'b00, c_S, 2'b00);
        cyc("busy1", 0, 1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, c_H, 2'b00, c_H, 2'b01);
        cyc("busy2", 0, 1, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, c_H, 2'b00, c_H, 2'b01);
        cyc("busy3", 0, 1, 0, 1, 1, 5'd6, 5'd6, 1, 5'd0, 0, c_H, 2'b00, c_H, 2'b01);
        cyc("busy4", 0, 1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, c_H, 2'b00, c_H, 2'b01);
        idle("unbusy1", c_N, 2'b00, c_S, 2'b01);
        idle("unbusy2", c_N, 2'b00, c_S, 2'b01);
        idle("unbusy3", c_N, 2'b00, c_N, 2'b00);
`ifdef HAZARD_PERF_CNT_EN
        check("stall_cnt1_b", sc1, 32'd8);
        check("stall_cnt3_b", sc3, 32'd14);
        check("flush_cnt3_b", fc3, 32'd2);
`endif

        // Reset (with Mem_Busy also high) in the middle of a stall
        cyc("lu_b4rst", 0, 0, 0, 1, 1, 5'd8, 5'd0, 0, 5'd8, 1, c_S, 2'b00, c_S, 2'b00);
        cyc("rst_in_ls", 1, 1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, c_R, 2'b00, c_R, 2'b01);
        idle("post_rst1", c_N, 2'b00, c_N, 2'b00);
        idle("post_rst2", c_N, 2'b00, c_N, 2'b00);
`ifdef HAZARD_PERF_CNT_EN
        check("stall_cnt3_c", sc3, 32'd0);
        check("flush_cnt3_c", fc3, 32'd0);
        check("stall_cnt1_c", sc1, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
`default_nettype wire
